mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8:1 single-bit mux datapath among 8 requesters.
- Drives the mux select `s` from a grant state machine and enforces a per-grant burst limit.
- Registers the selected bit onto `o` with a valid flag.
- Sits directly in front of the existing `mux_8x1`, which it instantiates for the data path.

---
 rtl/mux8_arb_pkg.sv | 26 ++
 rtl/mux_8x1.sv | 16 +
 rtl/rr_pick.sv | 30 +++
 rtl/mux8_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mux8_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : mux8_arb_pkg                                           |
// | Shared state encoding, sizes and helpers for mux8_rr_arbiter.    |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_8x1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : mux_8x1                                                |
// | Single-bit 8:1 multiplexer; o = i[s].                            |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module mux_8x1 (
    input  logic [7:0] i,
    input  logic [2:0] s,
    output logic       o
);

    assign o = i[s];

endmodule
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rr_pick                                                |
// | Round-robin pick: first set req bit scanning ptr+1 .. ptr+8.     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // The last candidate (k = N_REQ) wraps back to ptr itself, which lets a
    // sole requester be re-granted after its own release.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[ptr + SEL_W'(k)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : mux8_rr_arbiter                                        |
// | Round-robin burst-limited arbiter sharing one mux_8x1 datapath.  |
// | Option  : MUX8_RR_ARBITER_LOCK_EN adds a per-requester lock input|
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8,
    parameter int GAP       = 0
) (
`ifdef MUX8_RR_ARBITER_LOCK_EN
    input  logic [7:0] lock,
`endif
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] i,
    output logic [7:0] gnt,
    output logic [2:0] s,
    output logic       o,
    output logic       o_vld,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    arb_state_t         r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_n;
    logic [SEL_W-1:0]   r_ptr,   w_ptr_n;
    logic [SEL_W-1:0]   r_s,     w_s_n;
    logic [N_REQ-1:0]   r_gnt,   w_gnt_n;
    logic               r_o, r_o_vld;
    logic               w_found, w_mux_o, w_req_s, w_lock_s, w_hold;
    logic [SEL_W-1:0]   w_idx;

`ifdef MUX8_RR_ARBITER_LOCK_EN
    assign w_lock_s = lock[r_s];
`else
    assign w_lock_s = 1'b0;
`endif

    assign w_req_s = req[r_s];
    // A lock only defeats the burst limit; dropping req still releases.
    assign w_hold  = w_req_s && ((r_cnt < c_max) || w_lock_s);

    // ptr always equals s while granting, so one picker serves every state.
    rr_pick u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    mux_8x1 u_mux (
        .i (i),
        .s (r_s),
        .o (w_mux_o)
    );

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_ptr_n   = r_ptr;
        w_s_n     = r_s;
        w_gnt_n   = r_gnt;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_found) begin
                    w_state_n = ST_GRANT;
                    w_gnt_n   = onehot8(w_idx);
                    w_s_n     = w_idx;
                    w_ptr_n   = w_idx;
                    w_cnt_n   = c_one;
                end else begin
                    w_state_n = ST_IDLE;
                    w_gnt_n   = '0;
                    w_cnt_n   = '0;
                end
            end
            ST_GRANT: begin
                if (w_hold) begin
                    if (r_cnt < c_max) begin
                        w_cnt_n = r_cnt + c_one;
                    end
                end else if (GAP != 0) begin
                    w_state_n = ST_GAP;
                    w_gnt_n   = '0;
                    w_cnt_n   = '0;
                end else if (w_found) begin
                    w_gnt_n   = onehot8(w_idx);
                    w_s_n     = w_idx;
                    w_ptr_n   = w_idx;
                    w_cnt_n   = c_one;
                end else begin
                    w_state_n = ST_IDLE;
                    w_gnt_n   = '0;
                    w_cnt_n   = '0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_gnt_n   = '0;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= SEL_W'(N_REQ - 1);
            r_s     <= '0;
            r_gnt   <= '0;
            r_o     <= 1'b0;
            r_o_vld <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_ptr   <= w_ptr_n;
            r_s     <= w_s_n;
            r_gnt   <= w_gnt_n;
            r_o_vld <= |r_gnt;
            if (|r_gnt) begin
                r_o <= w_mux_o;
            end
        end
    end

    assign gnt   = r_gnt;
    assign s     = r_s;
    assign o     = r_o;
    assign o_vld = r_o_vld;
    assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_mux8_rr_arbiter                                     |
// | Directed + random bench for mux8_rr_arbiter (GAP=0 and GAP=1).   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_mux8_rr_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;

    logic [7:0] gnt0, gnt1;
    logic [2:0] s0, s1;
    logic       o0, o1, vld0, vld1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 when nobody granted), burst count,
    // last-grant pointer, select, state (0 idle, 1 grant, 2 gap), data regs.
    int   m_own[2], m_cnt[2], m_ptr[2], m_s[2], m_state[2];
    logic m_o[2], m_vld[2];

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_BURST(MAXB), .CNT_W(8), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .i(din),
        .gnt(gnt0), .s(s0), .o(o0), .o_vld(vld0), .busy(busy0)
    );

    mux8_rr_arbiter #(.MAX_BURST(MAXB), .CNT_W(8), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .i(din),
        .gnt(gnt1), .s(s1), .o(o1), .o_vld(vld1), .busy(busy1)
    );

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 1; k <= 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic give(input int g, input int w);
        m_own[g] = w; m_s[g] = w; m_ptr[g] = w; m_cnt[g] = 1; m_state[g] = 1;
    endtask

    task automatic model_edge(input int g, input int gap);
        int w;
        if (rst) begin
            m_own[g] = -1; m_cnt[g] = 0; m_ptr[g] = 7; m_s[g] = 0;
            m_state[g] = 0; m_o[g] = 1'b0; m_vld[g] = 1'b0;
            return;
        end
        if (m_own[g] >= 0) m_o[g] = din[m_own[g]];
        m_vld[g] = (m_own[g] >= 0);
        if (m_state[g] != 1) begin
            w = pick(req, m_ptr[g]);
            if (w >= 0) give(g, w);
            else begin m_state[g] = 0; m_own[g] = -1; end
        end else if (req[m_own[g]] && m_cnt[g] < MAXB) begin
            m_cnt[g]++;
        end else if (gap != 0) begin
            m_state[g] = 2; m_own[g] = -1;
        end else begin
            w = pick(req, m_own[g]);
            if (w >= 0) give(g, w);
            else begin m_state[g] = 0; m_own[g] = -1; end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_gnt(input int g);
        return (m_own[g] >= 0) ? 8'(1 << m_own[g]) : 8'h00;
    endfunction

    task automatic compare_all();
        chk("m0_gnt",  gnt0, exp_gnt(0));
        chk("m0_s",    {5'd0, s0}, 8'(m_s[0]));
        chk("m0_o",    {7'd0, o0}, {7'd0, m_o[0]});
        chk("m0_vld",  {7'd0, vld0}, {7'd0, m_vld[0]});
        chk("m0_busy", {7'd0, busy0}, {7'd0, m_state[0] != 0});
        chk("m1_gnt",  gnt1, exp_gnt(1));
        chk("m1_s",    {5'd0, s1}, 8'(m_s[1]));
        chk("m1_o",    {7'd0, o1}, {7'd0, m_o[1]});
        chk("m1_vld",  {7'd0, vld1}, {7'd0, m_vld[1]});
        chk("m1_busy", {7'd0, busy1}, {7'd0, m_state[1] != 0});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, 0);
        model_edge(1, 1);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] gap_seq [11];

    initial begin
        gap_seq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02,
                    8'h02, 8'h02, 8'h02, 8'h00, 8'h01};
        rst = 1'b1; req = 8'h00; din = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_gnt", gnt0, 8'h00);
            chk("idle_busy", {7'd0, busy0}, 8'h00);
            chk("idle_vld", {7'd0, vld0}, 8'h00);
        end

        // Sole requester 3: continuous re-grant
        req = 8'h08; din = 8'h08;
        tick();
        chk("single_gnt_c1", gnt0, 8'h08);
        chk("single_s_c1", {5'd0, s0}, 8'h03);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("single_gnt", gnt0, 8'h08);
            chk("single_o", {7'd0, o0}, 8'h01);
            chk("single_vld", {7'd0, vld0}, 8'h01);
        end

        // Burst rotation with all requesting
        req = 8'h00;
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 36; c++) begin
            tick();
            chk("rot_nz", {7'd0, |gnt0}, 8'h01);
            chk("rot_s", {5'd0, s0}, 8'((c / MAXB) % 8));
        end

        // Early drop of requester 0
        req = 8'h00;
        do_reset();
        req = 8'h21;
        tick(); chk("drop_c1", gnt0, 8'h01);
        tick(); chk("drop_c2", gnt0, 8'h01);
        req = 8'h20;
        tick(); chk("drop_c3", gnt0, 8'h20);

        // Dead-cycle handoff on the GAP=1 instance
        req = 8'h00;
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 11; c++) begin
            tick();
            chk("gap_seq", gnt1, gap_seq[c]);
        end

        // Reset in the middle of requester 5's burst
        req = 8'h00;
        do_reset();
        req = 8'h20;
        tick(); tick();
        rst = 1'b1; req = 8'hFF;
        tick();
        chk("rstmid_gnt", gnt0, 8'h00);
        chk("rstmid_s", {5'd0, s0}, 8'h00);
        rst = 1'b0;
        tick();
        chk("rstmid_first", gnt0, 8'h01);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            req = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'h00;
            din = 8'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
